// File: rtl/max7219_rx.sv
// Receiver for the 3-wire MAX7219-style link (DIN/CLK/LOAD): oversamples the link on clk,
// shifts frames MSB-first and commits them on LOAD rise into a mirror of the display registers.
module max7219_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        sck,
    input  logic        load,
    output logic        dout,
    output logic [63:0] digits,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown_n,
    output logic        display_test,
    output logic        wr_stb,
    output logic [3:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_err
);

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic [SYNC_STAGES-1:0] r_din_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic                   r_sck_d;
    logic                   r_load_d;
    logic [FRAME_BITS-1:0]  r_sr;
    logic [4:0]             r_bit_cnt;
    logic                   r_dout;
    logic                   r_wr_stb;
    logic                   r_frame_err;
    logic [3:0]             r_wr_addr;
    logic [7:0]             r_wr_data;
    logic [63:0]            r_digits;
    logic [7:0]             r_decode_mode;
    logic [3:0]             r_intensity;
    logic [2:0]             r_scan_limit;
    logic                   r_shutdown_n;
    logic                   r_display_test;

    logic                   w_din_s;
    logic                   w_sck_s;
    logic                   w_load_s;
    logic                   w_sck_rise;
    logic                   w_load_rise;
    logic [FRAME_BITS-1:0]  w_sr_next;
    logic [4:0]             w_cnt_next;
    logic                   w_frame_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din_sync  <= '0;
            r_sck_sync  <= '0;
            r_load_sync <= '0;
            r_sck_d     <= 1'b0;
            r_load_d    <= 1'b0;
        end else begin
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], din};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], load};
            r_sck_d     <= w_sck_s;
            r_load_d    <= w_load_s;
        end
    end

    // A sck rise coinciding with a load rise is folded in before the latch decision,
    // so the bit shifted on that cycle belongs to the committed frame.
    always_comb begin
        w_din_s      = r_din_sync[SYNC_STAGES-1];
        w_sck_s      = r_sck_sync[SYNC_STAGES-1];
        w_load_s     = r_load_sync[SYNC_STAGES-1];
        w_sck_rise   = w_sck_s & ~r_sck_d;
        w_load_rise  = w_load_s & ~r_load_d;
        w_sr_next    = r_sr;
        w_cnt_next   = r_bit_cnt;
        if (w_sck_rise) begin
            w_sr_next = {r_sr[FRAME_BITS-2:0], w_din_s};
            if (r_bit_cnt != 5'd31) begin
                w_cnt_next = r_bit_cnt + 5'd1;
            end
        end
        w_frame_full = (w_cnt_next >= FRAME_CNT);
    end

    // wr_stb is a single-cycle pulse; wr_addr/wr_data are valid with it and hold until the next commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_dout      <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_sr        <= w_sr_next;
            r_bit_cnt   <= w_load_rise ? 5'd0 : w_cnt_next;
            r_wr_stb    <= w_load_rise & w_frame_full;
            r_frame_err <= w_load_rise & ~w_frame_full;
            if (w_sck_rise) begin
                r_dout <= r_sr[FRAME_BITS-1];
            end
            if (w_load_rise && w_frame_full) begin
                r_wr_addr <= w_sr_next[11:8];
                r_wr_data <= w_sr_next[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits       <= '0;
            r_decode_mode  <= '0;
            r_intensity    <= '0;
            r_scan_limit   <= '0;
            r_shutdown_n   <= 1'b0;
            r_display_test <= 1'b0;
        end else if (r_wr_stb) begin
            case (r_wr_addr)
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8:
                    r_digits[{r_wr_addr[2:0] - 3'd1, 3'b000} +: 8] <= r_wr_data;
                4'd9:    r_decode_mode  <= r_wr_data;
                4'd10:   r_intensity    <= r_wr_data[3:0];
                4'd11:   r_scan_limit   <= r_wr_data[2:0];
                4'd12:   r_shutdown_n   <= r_wr_data[0];
                4'd13:   r_display_test <= r_wr_data[0];
                default: ;
            endcase
        end
    end

    assign dout         = r_dout;
    assign digits       = r_digits;
    assign decode_mode  = r_decode_mode;
    assign intensity    = r_intensity;
    assign scan_limit   = r_scan_limit;
    assign shutdown_n   = r_shutdown_n;
    assign display_test = r_display_test;
    assign wr_stb       = r_wr_stb;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_max7219_rx.sv
// Bench for max7219_rx: drives the serial link at half-period 5 clk and checks the
// register file, strobes and daisy-chain output against a bit-history model.
module tb_max7219_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        sck = 1'b0;
    logic        load = 1'b0;
    logic        dout;
    logic [63:0] digits;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n;
    logic        display_test;
    logic        wr_stb;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_err;

    max7219_rx #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sck(sck), .load(load), .dout(dout),
        .digits(digits), .decode_mode(decode_mode), .intensity(intensity),
        .scan_limit(scan_limit), .shutdown_n(shutdown_n), .display_test(display_test),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Observed pulse-cycle counts and the address/data seen while wr_stb was high.
    int          stb_cnt = 0;
    int          err_cnt = 0;
    logic [3:0]  cap_addr = '0;
    logic [7:0]  cap_data = '0;
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            stb_cnt++;
            cap_addr = wr_addr;
            cap_data = wr_data;
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    // Reference model: every bit shifted since reset, and the bits since the last load.
    logic        hist[$];
    int          since_load;
    logic [63:0] m_digits;
    logic [7:0]  m_decode;
    logic [3:0]  m_int;
    logic [2:0]  m_scan;
    logic        m_shut, m_test;
    logic [3:0]  m_addr;
    logic [7:0]  m_data;
    int          m_stb = 0;
    int          m_err = 0;
    logic        exp_dout_q[$];
    logic        obs_dout_q[$];
    logic [70:0] m_regs, d_regs;

    task automatic model_reset();
        hist.delete();
        since_load = 0;
        m_digits = '0; m_decode = '0; m_int = '0; m_scan = '0;
        m_shut = 1'b0; m_test = 1'b0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_load();
        logic [15:0] v;
        if (since_load >= 16) begin
            for (int i = 0; i < 16; i++) v[i] = hist[hist.size() - 1 - i];
            m_stb++;
            m_addr = v[11:8];
            m_data = v[7:0];
            if (m_addr >= 4'd1 && m_addr <= 4'd8) m_digits[8 * (int'(m_addr) - 1) +: 8] = m_data;
            else if (m_addr == 4'd9)  m_decode = m_data;
            else if (m_addr == 4'd10) m_int = m_data[3:0];
            else if (m_addr == 4'd11) m_scan = m_data[2:0];
            else if (m_addr == 4'd12) m_shut = m_data[0];
            else if (m_addr == 4'd13) m_test = m_data[0];
        end else begin
            m_err++;
        end
        since_load = 0;
    endtask

    task automatic snap_regs();
        m_regs = {m_digits, m_decode, m_int, m_scan, m_shut, m_test};
        d_regs = {digits, decode_mode, intensity, scan_limit, shutdown_n, display_test};
    endtask

    // Driver: one bit per call; din changes at sck fall and is held across the rise.
    task automatic send_bit(input logic b, input logic with_load);
        int k;
        din = b;
        repeat (5) @(negedge clk);
        sck = 1'b1;
        if (with_load) load = 1'b1;
        hist.push_back(b);
        since_load++;
        k = hist.size();
        exp_dout_q.push_back(k >= 17 ? hist[k - 17] : 1'b0);
        repeat (5) @(negedge clk);
        obs_dout_q.push_back(dout);
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], 1'b0);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        repeat (5) @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        model_load();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        snap_regs();
        n_vec++; if (d_regs !== m_regs) begin n_err++; $display("FAIL reset_regs: got %h expected %h", d_regs, m_regs); end
        n_vec++; if ({wr_stb, wr_addr, wr_data, frame_err, dout} !== 15'd0) begin
            n_err++; $display("FAIL reset_strobes: got %h expected 0", {wr_stb, wr_addr, wr_data, frame_err, dout}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_shutdown();
        int s0 = stb_cnt, e0 = err_cnt;
        send_bits(32'h0C01, 16);
        pulse_load();
        n_vec++; if (shutdown_n !== m_shut || m_shut !== 1'b1) begin n_err++; $display("FAIL shutdown: got %b expected %b", shutdown_n, m_shut); end
        n_vec++; if (stb_cnt - s0 !== 1) begin n_err++; $display("FAIL shutdown_stb: got %0d pulses expected 1", stb_cnt - s0); end
        n_vec++; if ({cap_addr, cap_data} !== 12'hC01) begin n_err++; $display("FAIL shutdown_wr: got %h expected C01", {cap_addr, cap_data}); end
        n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL shutdown_err: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_digits();
        send_bits(32'h035B, 16);
        pulse_load();
        send_bits(32'h0812, 16);
        pulse_load();
        n_vec++; if (digits !== m_digits) begin n_err++; $display("FAIL digits: got %h expected %h", digits, m_digits); end
        n_vec++; if (digits !== 64'h1200_0000_005B_0000) begin n_err++; $display("FAIL digits_layout: got %h expected 1200000000 5b0000", digits); end
    endtask

    task automatic test_short_frame();
        int s0 = stb_cnt, e0 = err_cnt;
        send_bits(32'h0A, 8);
        pulse_load();
        n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL short_err: got %0d pulses expected 1", err_cnt - e0); end
        n_vec++; if (stb_cnt - s0 !== 0) begin n_err++; $display("FAIL short_stb: got %0d pulses expected 0", stb_cnt - s0); end
        n_vec++; if (intensity !== 4'd0) begin n_err++; $display("FAIL short_intensity: got %h expected 0", intensity); end
        n_vec++; if ({wr_addr, wr_data} !== 12'h812) begin n_err++; $display("FAIL short_wr_hold: got %h expected 812", {wr_addr, wr_data}); end
    endtask

    task automatic test_overlong();
        logic [7:0] tail;
        exp_dout_q.delete();
        obs_dout_q.delete();
        send_bits(32'hAA0A05, 24);
        pulse_load();
        n_vec++; if (intensity !== m_int || m_int !== 4'd5) begin n_err++; $display("FAIL overlong_intensity: got %h expected %h", intensity, m_int); end
        for (int i = 0; i < 24; i++) begin
            n_vec++; if (obs_dout_q[i] !== exp_dout_q[i]) begin n_err++; $display("FAIL dout_bit%0d: got %b expected %b", i + 1, obs_dout_q[i], exp_dout_q[i]); end
        end
        for (int i = 0; i < 8; i++) tail[7 - i] = obs_dout_q[16 + i];
        n_vec++; if (tail !== 8'hAA) begin n_err++; $display("FAIL dout_tail: got %h expected aa", tail); end
    endtask

    task automatic test_noop_addrs();
        int s0 = stb_cnt;
        send_bits(32'h0E55, 16);
        pulse_load();
        snap_regs();
        n_vec++; if (d_regs !== m_regs) begin n_err++; $display("FAIL noop_regs: got %h expected %h", d_regs, m_regs); end
        n_vec++; if (cap_addr !== 4'hE) begin n_err++; $display("FAIL noop_addr: got %h expected e", cap_addr); end
        send_bits(32'hF905, 16);
        pulse_load();
        n_vec++; if (stb_cnt - s0 !== 2) begin n_err++; $display("FAIL noop_stb: got %0d pulses expected 2", stb_cnt - s0); end
        n_vec++; if (decode_mode !== 8'h05) begin n_err++; $display("FAIL decode_mode: got %h expected 05", decode_mode); end
    endtask

    task automatic test_reset_midframe();
        int s0, e0;
        send_bits(32'h0B07 >> 7, 9);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        snap_regs();
        n_vec++; if (d_regs !== m_regs) begin n_err++; $display("FAIL midreset_regs: got %h expected %h", d_regs, m_regs); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        s0 = stb_cnt; e0 = err_cnt;
        send_bits(32'h0B07, 16);
        pulse_load();
        n_vec++; if (scan_limit !== 3'd7) begin n_err++; $display("FAIL midreset_scan: got %0d expected 7", scan_limit); end
        n_vec++; if (stb_cnt - s0 !== 1) begin n_err++; $display("FAIL midreset_stb: got %0d expected 1", stb_cnt - s0); end
        n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL midreset_err: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_simultaneous_edge();
        logic [15:0] f = {4'h3, 4'd13, 8'h01};
        send_bits(32'(f >> 1), 15);
        send_bit(f[0], 1'b1);
        load = 1'b0;
        repeat (6) @(negedge clk);
        model_load();
        n_vec++; if (stb_cnt !== m_stb) begin n_err++; $display("FAIL simul_stb: got %0d expected %0d", stb_cnt, m_stb); end
        n_vec++; if (display_test !== m_test || m_test !== 1'b1) begin n_err++; $display("FAIL simul_test: got %b expected %b", display_test, m_test); end
        n_vec++; if (err_cnt !== m_err) begin n_err++; $display("FAIL simul_err: got %0d expected %0d", err_cnt, m_err); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            logic [15:0] f = {4'($urandom), 4'($urandom_range(0, 15)), 8'($urandom)};
            if ($urandom_range(0, 3) == 0) begin
                send_bits($urandom, $urandom_range(1, 15));
            end else begin
                send_bits($urandom, $urandom_range(0, 6));
                send_bits(32'(f), 16);
            end
            pulse_load();
            snap_regs();
            n_vec++; if (d_regs !== m_regs) begin n_err++; $display("FAIL rand%0d_regs: got %h expected %h", it, d_regs, m_regs); end
            n_vec++; if (stb_cnt !== m_stb || err_cnt !== m_err) begin n_err++;
                $display("FAIL rand%0d_pulses: got stb %0d err %0d expected stb %0d err %0d", it, stb_cnt, err_cnt, m_stb, m_err); end
            n_vec++; if ({wr_addr, wr_data} !== {m_addr, m_data}) begin n_err++;
                $display("FAIL rand%0d_wr: got %h expected %h", it, {wr_addr, wr_data}, {m_addr, m_data}); end
        end
        while (obs_dout_q.size() > 0) begin
            logic o = obs_dout_q.pop_front();
            logic e = exp_dout_q.pop_front();
            n_vec++; if (o !== e) begin n_err++; $display("FAIL rand_dout: got %b expected %b", o, e); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_shutdown();
        test_digits();
        test_short_frame();
        test_overlong();
        test_noop_addrs();
        test_reset_midframe();
        test_simultaneous_edge();
        exp_dout_q.delete();
        obs_dout_q.delete();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
